bsg_counter_interval_sched: RTL and testbench
=============================================

// Module: bsg_counter_interval_sched
// PURPOSE
//  Time-shares one settable/enabled interval counter (0..max_val_p) among els_p requesters.
//  Each requester asks for an interval of len cycles; a round-robin arbiter grants one at a time.
//  The block loads the counter, enables it while not paused, and pulses done to the owner when the interval expires.
//  Sits between client FSMs (e.g. timeout/backoff logic) and a single shared bsg_counter_set_en-style timer.
// PARAMETERS
//  els_p       4    number of requesters (>=1)
//  max_val_p   50   largest honoured interval length; longer requests are clamped to it
//  width_p     6    counter/length width; must be >= $clog2(max_val_p+1)
// PORTS
//  clk_i      in   1                 single clock, posedge
//  reset_i    in   1                 asynchronous, active-high reset
//  v_i        in   els_p             per-requester request valid
//  len_i      in   els_p*width_p     per-requester interval length; slice i = len_i[i*width_p+:width_p]
//  yumi_o     out  els_p             one-hot accept; request i consumed this cycle
//  pause_i    in   1                 freezes the running counter (enable low)
//  abort_i    in   1                 cancels the running interval, no done
//  done_o     out  els_p             one-hot, one-cycle pulse to the owner at interval end
//  busy_o     out  1                 high in RUN or DONE
//  owner_o    out  max(1,$clog2(els_p))  index of current/last owner
//  count_o    out  width_p           shared counter value
// BEHAVIOUR
//  Reset (async assert, sync-safe deassert): state=IDLE, count_o=0, owner_o=0, yumi_o=0, done_o=0,
//   busy_o=0, rr pointer so requester 0 has highest priority. Reset mid-interval drops it silently.
//  States: IDLE, RUN, DONE.
//  IDLE: if any v_i, grant the first valid index at or after rr_ptr (wrapping); yumi_o[g]=1
//   combinationally this cycle (valid-then-yumi, yumi depends on v_i, never on yumi). Capture
//   lim=min(len_i[g],max_val_p), owner_o<=g, rr_ptr<=(g+1) mod els_p, count_o<=0 (set).
//   lim==0 -> next DONE; else -> RUN. No v_i -> stay, yumi_o=0.
//  RUN: count_o increments by 1 each cycle pause_i=0 (enable); holds when pause_i=1.
//   If count_o==lim-1 and pause_i=0 -> DONE (count_o becomes lim). Never wraps; never exceeds max_val_p.
//  DONE: done_o[owner_o]=1 for exactly this cycle, yumi_o=0; -> IDLE, count_o<=0.
//  abort_i: in RUN -> IDLE next cycle, count_o<=0, no done; abort wins over simultaneous expiry.
//   Ignored in IDLE and DONE (done still pulses).
//  pause_i ignored outside RUN. v_i of non-granted requesters is held by the client; no queueing here.
//  Latency: accept at cycle t, RUN t+1..t+lim (unpaused), done_o at t+lim+1, next yumi earliest t+lim+2.
//  Outputs yumi_o/done_o are at most one-hot; busy_o registered-state decode.
// TESTING
//  1 reset, v_i[2]=1 len=5, no pause -> yumi_o=4'b0100 at t, count 0..4, done_o=4'b0100 at t+6, owner_o=2.
//  2 v_i=4'b1111 held, len=1 each -> grants 0,1,2,3,0 in order, each done 2 cycles after yumi, yumi every 3 cycles.
//  3 len=63 (>max) -> clamped, count reaches 50, done after 51 cycles; count_o never >50.
//  4 len=0 -> yumi at t, done at t+1, count_o stays 0.
//  5 len=10, pause_i high 3 cycles mid-run -> count holds, done 3 cycles later (t+14); abort_i at count=9 -> no done, IDLE.
//  6 reset_i pulsed asynchronously mid-RUN -> all outputs 0 immediately, next grant goes to requester 0.

Source files
------------

// File: rtl/bsg_counter_interval_sched.sv
// Shares one interval counter among els_p requesters, granting them round-robin.
// Latency: the grant (yumi_o) is combinational from v_i. done_o fires lim+1 cycles after the grant, or one cycle later for each paused cycle.
// Backpressure: a requester holds v_i until it sees its yumi_o bit; nothing is queued. At most one interval is in flight.
//
// Ports:
//   clk_i, reset_i      clock (posedge) and asynchronous active-high reset
//   v_i, len_i          per-requester valid and interval length (slice i = len_i[i*width_p+:width_p])
//   yumi_o              one-hot accept, only in IDLE
//   pause_i, abort_i    freeze or cancel the running interval
//   done_o              one-hot, one-cycle pulse to the owner when its interval ends
//   busy_o, owner_o     an interval is in flight (RUN or DONE) / index of the current or last owner
//   count_o             value of the shared counter
module bsg_counter_interval_sched #(
  parameter int els_p      = 4,
  parameter int max_val_p  = 50,
  parameter int width_p    = 6,
  localparam int owner_w_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [els_p-1:0]         v_i,
  input  logic [els_p*width_p-1:0] len_i,
  output logic [els_p-1:0]         yumi_o,
  input  logic                     pause_i,
  input  logic                     abort_i,
  output logic [els_p-1:0]         done_o,
  output logic                     busy_o,
  output logic [owner_w_lp-1:0]    owner_o,
  output logic [width_p-1:0]       count_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                state_r, state_n;
  logic [width_p-1:0]    count_r, lim_r;
  logic [width_p-1:0]    len_g, lim_g;
  logic [owner_w_lp-1:0] owner_r, rr_r, grant_idx;
  logic                  grant_v;
  logic                  expire;
  logic [2*els_p-1:0]    v_dbl;

  // Two copies of v_i side by side let the search walk upward from rr_r and
  // wrap around without a modulo on the bit index.
  assign v_dbl = {v_i, v_i};

  // The loop runs from the far end down to rr_r. Each valid bit overwrites
  // the result, so the nearest valid index at or after rr_r is the one that
  // remains.
  always_comb begin
    grant_v   = 1'b0;
    grant_idx = '0;
    for (int k = els_p - 1; k >= 0; k--) begin
      if (v_dbl[int'(rr_r) + k]) begin
        grant_v   = 1'b1;
        grant_idx = owner_w_lp'((int'(rr_r) + k) % els_p);
      end
    end
  end

  assign len_g = len_i[int'(grant_idx)*width_p +: width_p];
  assign lim_g = (len_g > width_p'(max_val_p)) ? width_p'(max_val_p) : len_g;

  // lim_r is at least 1 whenever the FSM is in RUN, so lim_r-1 cannot underflow here.
  assign expire = (count_r == lim_r - width_p'(1)) && !pause_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= IDLE;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: if (grant_v) state_n = (lim_g == '0) ? DONE : RUN;
      // abort_i is checked before expire, so an abort in the same cycle as expiry cancels the interval.
      RUN: begin
        if (abort_i)     state_n = IDLE;
        else if (expire) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    yumi_o = '0;
    done_o = '0;
    for (int i = 0; i < els_p; i++) begin
      yumi_o[i] = (state_r == IDLE) && grant_v && (grant_idx == owner_w_lp'(i));
      done_o[i] = (state_r == DONE) && (owner_r == owner_w_lp'(i));
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_r <= '0;
      lim_r   <= '0;
      owner_r <= '0;
      rr_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_v) begin
            lim_r   <= lim_g;
            owner_r <= grant_idx;
            rr_r    <= (grant_idx == owner_w_lp'(els_p - 1)) ? '0 : grant_idx + owner_w_lp'(1);
            count_r <= '0;
          end
        end
        RUN: begin
          // On expiry the counter steps to lim_r. That value is at most max_val_p, so the counter never wraps.
          if (abort_i)       count_r <= '0;
          else if (!pause_i) count_r <= count_r + width_p'(1);
        end
        DONE:    count_r <= '0;
        default: count_r <= '0;
      endcase
    end
  end

  assign busy_o  = (state_r != IDLE);
  assign owner_o = owner_r;
  assign count_o = count_r;

endmodule

// File: tb/tb_bsg_counter_interval_sched.sv
module tb_bsg_counter_interval_sched;

  localparam int EL = 4;
  localparam int W  = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic [EL-1:0]   v_i;
  logic [EL*W-1:0] len_i;
  logic [EL-1:0]   yumi_o;
  logic            pause_i;
  logic            abort_i;
  logic [EL-1:0]   done_o;
  logic            busy_o;
  logic [1:0]      owner_o;
  logic [W-1:0]    count_o;

  bsg_counter_interval_sched #(.els_p(EL), .max_val_p(50), .width_p(W)) dut (
    .clk_i(clk), .reset_i(rst), .v_i(v_i), .len_i(len_i), .yumi_o(yumi_o),
    .pause_i(pause_i), .abort_i(abort_i), .done_o(done_o), .busy_o(busy_o),
    .owner_o(owner_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_done;
    logic [3:0] vec;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic expect_evt(input bit is_done, input logic [3:0] vec, input int c);
    exp_t e;
    e.is_done = is_done;
    e.vec     = vec;
    e.cyc     = c;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input bit is_done, input logic [3:0] vec);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s got %b at cycle %0d, none expected",
               is_done ? "done" : "yumi", vec, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.is_done != is_done || e.vec != vec || e.cyc != cyc) begin
        errors++;
        $display("FAIL event got %s=%b at cycle %0d, want %s=%b at cycle %0d",
                 is_done ? "done" : "yumi", vec, cyc,
                 e.is_done ? "done" : "yumi", e.vec, e.cyc);
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents yumi or done.
  always @(negedge clk) begin
    if (!rst) begin
      if (yumi_o != '0) pop_cmp(1'b0, yumi_o);
      if (done_o != '0) pop_cmp(1'b1, done_o);
      if (count_o > W'(50)) chk("count_le_max", int'(count_o), 50);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_len(input int i, input int val);
    len_i[i*W +: W] = W'(val);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    v_i     = '0;
    pause_i = 1'b0;
    abort_i = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  initial begin
    rst = 1'b1; v_i = '0; len_i = '0; pause_i = 1'b0; abort_i = 1'b0;
    step(2);
    chk("rst_count", int'(count_o), 0);
    chk("rst_owner", int'(owner_o), 0);
    chk("rst_busy",  int'(busy_o),  0);
    chk("rst_yumi",  int'(yumi_o),  0);
    chk("rst_done",  int'(done_o),  0);
    rst = 1'b0;
    step(1);

    // Test 1: requester 2 with len 5, no pause. Count runs 0..4, then done at t+6.
    v_i = 4'b0100; set_len(2, 5);
    expect_evt(1'b0, 4'b0100, cyc);
    expect_evt(1'b1, 4'b0100, cyc + 6);
    step(1);
    v_i = '0;
    for (int k = 0; k < 5; k++) begin
      chk("t1_count", int'(count_o), k);
      step(1);
    end
    chk("t1_count_done", int'(count_o), 5);
    chk("t1_owner",      int'(owner_o), 2);
    chk("t1_busy",       int'(busy_o),  1);
    step(1);
    chk("t1_idle_busy",  int'(busy_o),  0);
    chk("t1_idle_count", int'(count_o), 0);

    // Test 2: all four request with len 1. Expect round-robin 0,1,2,3,0, with yumi every 3 cycles.
    do_reset();
    v_i = 4'b1111;
    for (int i = 0; i < EL; i++) set_len(i, 1);
    for (int k = 0; k < 5; k++) begin
      expect_evt(1'b0, 4'(1 << (k % 4)), cyc + 3*k);
      expect_evt(1'b1, 4'(1 << (k % 4)), cyc + 3*k + 2);
    end
    step(13);
    v_i = '0;
    step(3);

    // Test 3: len 63 is clamped to 50. Count reaches 50 and done comes at t+51.
    do_reset();
    v_i = 4'b1000; set_len(3, 63);
    expect_evt(1'b0, 4'b1000, cyc);
    expect_evt(1'b1, 4'b1000, cyc + 51);
    step(1);
    v_i = '0;
    step(49);
    chk("t3_count_49", int'(count_o), 49);
    step(1);
    chk("t3_count_50", int'(count_o), 50);
    step(3);

    // Test 5a: len 10 with 3 paused cycles. Done moves out to t+14.
    do_reset();
    v_i = 4'b0001; set_len(0, 10);
    expect_evt(1'b0, 4'b0001, cyc);
    expect_evt(1'b1, 4'b0001, cyc + 14);
    step(1);
    v_i = '0;
    step(2);
    pause_i = 1'b1;
    step(3);
    pause_i = 1'b0;
    chk("t5_paused_count", int'(count_o), 2);
    step(10);

    // Test 5b: abort when count is 9. No done follows and the block returns to IDLE.
    v_i = 4'b0010; set_len(1, 10);
    expect_evt(1'b0, 4'b0010, cyc);
    step(1);
    v_i = '0;
    step(9);
    chk("t5_pre_abort_count", int'(count_o), 9);
    abort_i = 1'b1;
    step(1);
    abort_i = 1'b0;
    chk("t5_abort_busy",  int'(busy_o),  0);
    chk("t5_abort_count", int'(count_o), 0);
    step(5);

    // Test 6: asynchronous reset mid-RUN, then a len-0 grant that must go to requester 0 (also covers test 4).
    v_i = 4'b0010; set_len(1, 20);
    expect_evt(1'b0, 4'b0010, cyc);
    step(1);
    v_i = '0;
    step(5);
    chk("t6_running", int'(busy_o), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_count", int'(count_o), 0);
    chk("t6_async_busy",  int'(busy_o),  0);
    chk("t6_async_owner", int'(owner_o), 0);
    chk("t6_async_done",  int'(done_o),  0);
    #1 rst = 1'b0;
    step(1);
    v_i = 4'b1111;
    for (int i = 0; i < EL; i++) set_len(i, 0);
    expect_evt(1'b0, 4'b0001, cyc);
    expect_evt(1'b1, 4'b0001, cyc + 1);
    step(1);
    v_i = '0;
    chk("t4_len0_count", int'(count_o), 0);
    chk("t4_len0_busy",  int'(busy_o),  1);
    step(4);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
